// File: rtl/qracc_pkg.sv
// Shared types and constants for the qracc write-back path.
package qracc_pkg;

  localparam int unsigned WBQ_CH_W       = 16;
  localparam int unsigned WBQ_DEF_DATA_W = 2048;
  localparam int unsigned WBQ_DEF_ADDR_W = 32;

  // Default-geometry set entry; the queue top re-declares it with its own widths.
  typedef struct packed {
    logic [WBQ_DEF_DATA_W-1:0] data;
    logic [WBQ_DEF_ADDR_W-1:0] base;
    logic [WBQ_DEF_ADDR_W-1:0] stride;
    logic [WBQ_CH_W-1:0]       channels;
    logic                      pack4;
  } wbq_set_t;

endpackage

// File: rtl/qracc_set_fifo.sv
// Synchronous set FIFO with full/empty flags; depth must be a power of two.
module qracc_set_fifo
  import qracc_pkg::*;
#(
  parameter int unsigned setDepth = 2,
  parameter type         entry_t  = wbq_set_t
) (
  input  logic   clk,
  input  logic   nrst,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o,
  output logic   one_left_o
);

  localparam int unsigned PW = (setDepth > 1) ? $clog2(setDepth) : 1;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  entry_t        mem_q [setDepth];
  logic          do_push, do_pop;

  assign full_o     = (count_q == (PW+1)'(setDepth));
  assign empty_o    = (count_q == '0);
  assign one_left_o = (count_q == (PW+1)'(1));
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign head_o     = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/qracc_writeback_queue.sv
// Set FIFO plus per-bank serializer feeding the activation-buffer write port.
// Nibble packing is built only when QRACC_WBQ_PACK4_EN is defined.
module qracc_writeback_queue
  import qracc_pkg::*;
#(
  parameter int unsigned numBanks            = 8,
  parameter int unsigned elementsPerBank     = 32,
  parameter int unsigned maxBits             = 8,
  parameter int unsigned writeInterfaceWidth = 256,
  parameter int unsigned addrWidth           = 32,
  parameter int unsigned setDepth            = 2
) (
  input  logic                                           clk,
  input  logic                                           nrst,
  input  logic                                           valid_i,
  output logic                                           ready_o,
  input  logic [numBanks*elementsPerBank*maxBits-1:0]    data_i,
  input  logic [addrWidth-1:0]                           base_addr_i,
  input  logic [addrWidth-1:0]                           bank_stride_i,
  input  logic [WBQ_CH_W-1:0]                            num_channels_i,
  input  logic                                           pack4_i,
  output logic                                           wr_valid_o,
  input  logic                                           wr_ready_i,
  output logic [addrWidth-1:0]                           wr_addr_o,
  output logic [writeInterfaceWidth-1:0]                 wr_data_o,
  output logic [writeInterfaceWidth/8-1:0]               wr_strb_o,
  output logic                                           set_done_o,
  output logic                                           idle_o
);

  localparam int unsigned SET_W  = numBanks*elementsPerBank*maxBits;
  localparam int unsigned STRB_W = writeInterfaceWidth/8;
  localparam int unsigned BW     = (numBanks > 1) ? $clog2(numBanks) : 1;
  localparam int unsigned MAX_CH = numBanks*elementsPerBank;
  localparam int unsigned NW     = WBQ_CH_W + 1;

  if (elementsPerBank*maxBits != writeInterfaceWidth) begin : g_bad_width
    $error("qracc_writeback_queue: elementsPerBank*maxBits must equal writeInterfaceWidth");
  end

  typedef struct packed {
    logic [SET_W-1:0]     data;
    logic [addrWidth-1:0] base;
    logic [addrWidth-1:0] stride;
    logic [WBQ_CH_W-1:0]  channels;
    logic                 pack4;
  } set_t;

  typedef enum logic {ST_EMPTY, ST_EMIT} state_e;

  set_t   push_set, head;
  logic   push, pop, fifo_full, fifo_empty, fifo_one_left;
  state_e state_q;
  logic [BW-1:0] b_q;

  logic [NW-1:0] ch_clip, nb, bank_lo, n_elem, n_bytes;
  logic [writeInterfaceWidth-1:0] bank_data, data_sel;
  logic [STRB_W-1:0] strb;
  logic emit, last_bank, hs;
`ifdef QRACC_WBQ_PACK4_EN
  logic [writeInterfaceWidth-1:0] packed_data;
`else
  logic unused_pack4;
  assign unused_pack4 = head.pack4;
`endif

  assign push     = valid_i && !fifo_full;
  assign push_set = '{data: data_i, base: base_addr_i, stride: bank_stride_i,
                      channels: num_channels_i, pack4: pack4_i};

  qracc_set_fifo #(.setDepth(setDepth), .entry_t(set_t)) u_set_fifo (
    .clk        (clk),
    .nrst       (nrst),
    .push_i     (push),
    .push_data_i(push_set),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .one_left_o (fifo_one_left)
  );

  always_comb begin
    ch_clip   = ({1'b0, head.channels} > NW'(MAX_CH)) ? NW'(MAX_CH) : {1'b0, head.channels};
    nb        = (ch_clip + NW'(elementsPerBank - 1)) / NW'(elementsPerBank);
    bank_lo   = NW'(b_q) * NW'(elementsPerBank);
    n_elem    = ch_clip - bank_lo;
    if (n_elem > NW'(elementsPerBank)) n_elem = NW'(elementsPerBank);
    emit      = (state_q == ST_EMIT) && (nb != '0);
    last_bank = (NW'(b_q) == nb - NW'(1));
    hs        = emit && wr_ready_i;
    // A zero-bank set retires on its first cycle at the head, with no write.
    pop       = (state_q == ST_EMIT) && ((nb == '0) || (hs && last_bank));
    bank_data = head.data[int'(b_q)*writeInterfaceWidth +: writeInterfaceWidth];
`ifdef QRACC_WBQ_PACK4_EN
    packed_data = '0;
    for (int k = 0; k < int'(elementsPerBank); k++)
      packed_data[4*k +: 4] = bank_data[int'(maxBits)*k +: 4];
    if (head.pack4) begin
      data_sel = packed_data;
      n_bytes  = (n_elem + NW'(1)) >> 1;
    end else begin
      data_sel = bank_data;
      n_bytes  = (n_elem * NW'(maxBits)) >> 3;
    end
`else
    data_sel = bank_data;
    n_bytes  = (n_elem * NW'(maxBits)) >> 3;
`endif
    strb = '0;
    for (int i = 0; i < int'(STRB_W); i++)
      strb[i] = (NW'(i) < n_bytes);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_EMPTY;
      b_q     <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) state_q <= ST_EMIT;
        ST_EMIT: begin
          if (pop) begin
            b_q <= '0;
            if (fifo_one_left && !push) state_q <= ST_EMPTY;
          end else if (hs) begin
            b_q <= b_q + 1'b1;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign ready_o    = !fifo_full;
  assign idle_o     = fifo_empty;
  assign set_done_o = pop;
  assign wr_valid_o = emit;
  assign wr_addr_o  = emit ? head.base + addrWidth'(b_q) * head.stride : '0;
  assign wr_data_o  = emit ? data_sel : '0;
  assign wr_strb_o  = emit ? strb : '0;

endmodule
